// File: rtl/mux_6to1_arbiter.sv
// mux_6to1_arbiter
//   Round-robin arbiter and sequencer for the shared 6-to-1 32-bit datapath mux.
//   Picks one of six requesters, drives the registered mux select, and presents
//   a valid/ready handshake to the single downstream consumer. Locked bursts are
//   bounded by MAX_BURST so that no requester can starve the others.
//
//   Optional feature macro: MUX6_ARB_PRIORITY_EN
//     defined   : source 0 wins every arbitration point and never moves ptr.
//     undefined : pure round-robin over all six sources.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset_n    in   1  asynchronous active-low reset
//   req        in   6  per-source request, held until its ack bit pulses
//   req_lock   in   6  per-source burst-continue hint, sampled at handshake
//   out_ready  in   1  consumer accepts the current mux output word
//   selector   out  3  registered mux select, always 0..5
//   grant      out  6  registered one-hot current owner
//   out_valid  out  1  registered, mux output valid for the consumer
//   ack        out  6  combinational transfer strobe for the owner
//   busy       out  1  registered, high while a source owns the mux
module mux_6to1_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] req,
    input  logic [5:0] req_lock,
    input  logic       out_ready,
    output logic [2:0] selector,
    output logic [5:0] grant,
    output logic       out_valid,
    output logic [5:0] ack,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANT   = 1'b1;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    // Returns {found, index}: first set candidate searching from last+1 upward,
    // wrapping 5->0. With the priority build, candidate 0 always wins.
    function automatic logic [3:0] pick_winner(input logic [5:0] cand,
                                               input logic [2:0] last);
        logic [3:0] res;
        logic [3:0] pos;
        res = 4'd0;
        // Walk from the farthest slot to the nearest so the nearest hit is kept.
        for (int i = 6; i >= 1; i--) begin
            pos = {1'b0, last} + 4'(i);
            if (pos >= 4'd6) begin
                pos = pos - 4'd6;
            end else begin
                pos = pos;
            end
            if (cand[pos[2:0]]) begin
                res = {1'b1, pos[2:0]};
            end else begin
                res = res;
            end
        end
`ifdef MUX6_ARB_PRIORITY_EN
        if (cand[0]) begin
            res = {1'b1, 3'd0};
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    logic [0:0] state_q,    state_d;
    logic [2:0] selector_q, selector_d;
    logic [5:0] grant_q,    grant_d;
    logic       valid_q,    valid_d;
    logic       busy_q,     busy_d;
    logic [2:0] ptr_q,      ptr_d;
    logic [3:0] cnt_q,      cnt_d;

    logic       hs_s;
    logic       own_req_s;
    logic       lock_go_s;
    logic       burst_end_s;
    logic       preempt_s;
    logic       load_s;
    logic [5:0] others_s;
    logic [3:0] win_s;

    assign hs_s        = valid_q & out_ready;
    assign own_req_s   = req[selector_q];
    assign lock_go_s   = hs_s & req_lock[selector_q] & own_req_s & (cnt_q < BURST_LAST);
    assign burst_end_s = hs_s & req_lock[selector_q] & own_req_s & (cnt_q >= BURST_LAST);
    // The current owner is never a candidate: after a handshake its request is
    // consumed, and after an abort its request bit is already low. In IDLE
    // grant_q is zero, so this is simply req.
    assign others_s    = req & ~grant_q;
    assign win_s       = pick_winner(others_s, ptr_q);

`ifdef MUX6_ARB_PRIORITY_EN
    assign preempt_s = others_s[0];
`else
    assign preempt_s = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/GRANT sequencer.
    always_comb begin
        state_d    = state_q;
        selector_d = selector_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        load_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_s[3]) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!hs_s && own_req_s) begin
                    // Stalled by the consumer: everything holds.
                    state_d = ST_GRANT;
                end else if (lock_go_s && !preempt_s) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (win_s[3]) begin
                    load_s = 1'b1;
                end else if (burst_end_s) begin
                    // Forced rotation found nobody else: restart the burst.
                    cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 6'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 6'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase

        if (load_s) begin
            state_d    = ST_GRANT;
            selector_d = win_s[2:0];
            grant_d    = 6'b000001 << win_s[2:0];
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = 4'd0;
`ifdef MUX6_ARB_PRIORITY_EN
            // Priority grants leave the round-robin position untouched.
            if (win_s[2:0] != 3'd0) begin
                ptr_d = win_s[2:0];
            end else begin
                ptr_d = ptr_q;
            end
`else
            ptr_d = win_s[2:0];
`endif
        end else begin
            ptr_d = ptr_d;
        end
    end

    // State and registered outputs; reset clears them asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            selector_q <= 3'd0;
            grant_q    <= 6'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= 3'd5;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            selector_q <= selector_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign selector  = selector_q;
    assign grant     = grant_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign ack       = grant_q & {6{valid_q & out_ready}};

endmodule

// File: tb/tb_mux_6to1_arbiter.sv
module tb_mux_6to1_arbiter;

    logic       clk;
    logic       reset_n;
    logic [5:0] req;
    logic [5:0] req_lock;
    logic       out_ready;
    logic [2:0] selector;
    logic [5:0] grant;
    logic       out_valid;
    logic [5:0] ack;
    logic       busy;

    int n_tests;
    int n_fail;
    int sb[$];

    mux_6to1_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_lock  (req_lock),
        .out_ready (out_ready),
        .selector  (selector),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Leaves the caller at a falling edge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req = 6'd0; req_lock = 6'd0; out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        req = 6'b111111; out_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({selector, grant, out_valid, busy, ack} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%0d grant=%b v=%b busy=%b ack=%b expected all zero",
                     selector, grant, out_valid, busy, ack);
        end
    endtask

    task automatic test_single();
        int exp;
        do_reset();
        req = 6'b000100; out_ready = 1'b1;
        sb.push_back(2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k >= 1) req = 6'd0;
            #1;
            if (k == 0) begin
                n_tests++;
                if (selector !== 3'd2 || grant !== 6'b000100 || out_valid !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_grant: got sel=%0d grant=%b v=%b busy=%b expected 2 000100 1 1",
                             selector, grant, out_valid, busy);
                end
            end
            if (ack !== 6'd0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL single_ack: got %b expected none", ack);
                end else begin
                    exp = sb.pop_front();
                    if (ack !== (6'b000001 << exp)) begin
                        n_fail++; $display("FAIL single_ack: got %b expected source %0d", ack, exp);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_end: got pending=%0d v=%b expected 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        req = 6'b111111; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) sb.push_back(k % 6);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (selector !== 3'(k % 6) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL rr_sel[%0d]: got %0d v=%b expected %0d 1", k, selector, out_valid, k % 6);
            end
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL rr_ack[%0d]: got %b expected none", k, ack);
            end else begin
                exp = sb.pop_front();
                if (ack !== (6'b000001 << exp)) begin
                    n_fail++; $display("FAIL rr_ack[%0d]: got %b expected source %0d", k, ack, exp);
                end
            end
        end
        @(negedge clk); req = 6'd0; out_ready = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_idle: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_burst();
        int exp;
        int seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        req = 6'b000011; req_lock = 6'b000011; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) sb.push_back(seq[k]);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL burst_ack[%0d]: got %b expected none", k, ack);
            end else begin
                exp = sb.pop_front();
                if (ack !== (6'b000001 << exp) || selector !== 3'(exp)) begin
                    n_fail++; $display("FAIL burst_ack[%0d]: got ack=%b sel=%0d expected source %0d", k, ack, selector, exp);
                end
            end
        end
        @(negedge clk); req = 6'd0; req_lock = 6'd0; out_ready = 1'b0;
    endtask

    task automatic test_lone_burst();
        do_reset();
        req = 6'b000010; req_lock = 6'b000010; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (ack !== 6'b000010 || selector !== 3'd1) begin
                n_fail++; $display("FAIL lone_burst[%0d]: got ack=%b sel=%0d expected 000010 1", k, ack, selector);
            end
        end
        @(negedge clk); req = 6'd0; req_lock = 6'd0; out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int exp;
        do_reset();
        req = 6'b001000; out_ready = 1'b0;
        sb.push_back(3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_tests++;
            if (selector !== 3'd3 || out_valid !== 1'b1 || ack !== 6'd0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got sel=%0d v=%b ack=%b expected 3 1 000000", k, selector, out_valid, ack);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k >= 1) req = 6'd0;
            #1;
            if (ack !== 6'd0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stall_ack: got %b expected none", ack);
                end else begin
                    exp = sb.pop_front();
                    if (ack !== (6'b000001 << exp)) begin
                        n_fail++; $display("FAIL stall_ack: got %b expected source %0d", ack, exp);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL stall_missing_ack: got pending=%0d expected 0", sb.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        do_reset();
        req = 6'b010000; out_ready = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (grant !== 6'b010000 || selector !== 3'd4) begin
            n_fail++; $display("FAIL abort_grant4: got grant=%b sel=%0d expected 010000 4", grant, selector);
        end
        @(negedge clk); req = 6'b000100; #1;
        @(negedge clk); #1;
        n_tests++;
        if (grant !== 6'b000100 || selector !== 3'd2 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_regrant: got grant=%b sel=%0d v=%b expected 000100 2 1", grant, selector, out_valid);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        n_tests++;
        if (ack !== 6'b000100) begin
            n_fail++; $display("FAIL abort_ack2: got %b expected 000100", ack);
        end
        reset_n = 1'b0; #1;
        n_tests++;
        if ({selector, grant, out_valid, busy, ack} !== 17'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got sel=%0d grant=%b v=%b busy=%b ack=%b expected all zero",
                               selector, grant, out_valid, busy, ack);
        end
        @(negedge clk); reset_n = 1'b1; req = 6'd0; out_ready = 1'b0;
    endtask

`ifdef MUX6_ARB_PRIORITY_EN
    task automatic test_priority();
        int exp;
        do_reset();
        req = 6'b000100; req_lock = 6'b000100; out_ready = 1'b1;
        sb.push_back(2); sb.push_back(0); sb.push_back(2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) req = 6'b000101;
            if (k == 2) req = 6'b000100;
            #1;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL prio_ack[%0d]: got %b expected none", k, ack);
            end else begin
                exp = sb.pop_front();
                if (ack !== (6'b000001 << exp) || selector !== 3'(exp)) begin
                    n_fail++; $display("FAIL prio_ack[%0d]: got ack=%b sel=%0d expected source %0d", k, ack, selector, exp);
                end
            end
        end
        @(negedge clk); req = 6'd0; req_lock = 6'd0; out_ready = 1'b0;
    endtask
`endif

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; req = 6'd0; req_lock = 6'd0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_lone_burst();
        test_stall();
        test_abort_and_reset();
`ifdef MUX6_ARB_PRIORITY_EN
        test_priority();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_6to1_arbiter.md
# mux_6to1_arbiter

- Round-robin arbiter and sequencer for the shared 6-to-1 32-bit datapath mux.
- Accepts requests from up to six sources and drives the registered 3-bit `selector` that steers the mux.
- Presents a valid/ready handshake toward the single downstream consumer.
- Supports locked bursts with a bounded length so no requester is starved.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum consecutive transfers one locked requester may hold the mux; legal range 1..15.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 6: per-source request; must stay high until the matching `ack` bit pulses.
- `req_lock` input 6: per-source burst-continue hint, sampled at handshake.
- `out_ready` input 1: downstream consumer accepts the word on the mux output.
- `selector` output 3: registered select to the mux (0..5 only).
- `grant` output 6: registered one-hot current owner.
- `out_valid` output 1: registered; mux output is valid for the consumer.
- `ack` output 6: combinational, equal to `grant & {6{out_valid & out_ready}}`; marks the transfer cycle.
- `busy` output 1: registered, high in GRANT.

## Operation
- States:
  - IDLE: no owner, `out_valid` = 0.
  - GRANT: one owner, `out_valid` = 1.
- Reset values: state IDLE, `selector` = 0, `grant` = 0, `out_valid` = 0, `busy` = 0, `ptr` (last granted) = 5, burst count = 0.
- Arbitration picks the first set `req` bit searching from `ptr+1` upward, wrapping 5→0.
- IDLE with any `req`: go to GRANT; load `selector`/`grant` with the winner, burst count = 0, `ptr` = winner.
- GRANT with handshake (`out_valid & out_ready`):
  - If `req_lock[sel]` & `req[sel]` & count < `MAX_BURST`-1: stay, count+1, same owner.
  - Else, if any other or new `req` is pending: re-arbitrate in the same cycle and go to GRANT with the new owner (no bubble).
  - Else: go to IDLE.
- Forced rotation: when the burst reaches `MAX_BURST` transfers, the owner is excluded from this re-arbitration. If it is the only requester, it is re-granted with count = 0.
- GRANT with `req[sel]` dropped before a handshake: abort; treated as completion without `ack`, and re-arbitration proceeds as above.
- GRANT with no handshake and `req[sel]` held: all registered outputs hold. `selector` never changes while `out_valid` = 1 without a handshake.
- Width rules:
  - `selector` is in 0..5; the mux default leg (6, 7) is never driven.
  - The burst counter is 4 bits and saturates at `MAX_BURST`-1.

## Timing
- Request-to-grant latency: 1 cycle. `req` is high at edge N, and `grant`/`selector`/`out_valid` are valid after edge N.
- Throughput: one transfer per cycle while `out_ready` = 1, including across owner changes.
- `ack` appears in the same cycle as the handshake. The requester may deassert `req` on the following edge.
- `reset_n` asserted mid-transfer: outputs clear immediately (asynchronous); no `ack` is issued for the interrupted word.
- `reset_n` deassertion is synchronized externally; the first arbitration happens on the first edge after release.
- Simultaneous requests: resolved by pointer order only. `req_lock` is ignored at initial grant.

## Configuration
- `MUX6_ARB_PRIORITY_EN` defined:
  - Source 0 is high priority. At every arbitration point `req[0]` wins over the round-robin order, including over a locked burst of another source after its current handshake.
  - Grants to source 0 do not update `ptr`.
- Not defined: pure round-robin across all six sources; source 0 is not special.

## Test plan
- Reset release, `req` = 6'b000100 → after 1 edge: `selector` = 2, `grant` = 6'b000100, `out_valid` = 1; with `out_ready` = 1, `ack[2]` pulses once.
- `req` = 6'b111111 held, `out_ready` = 1, no lock → `selector` sequence 0,1,2,3,4,5,0 on consecutive cycles with no idle bubble.
- `MAX_BURST` = 4, `req_lock` = `req` = 6'b000011 → source 0 gets 4 transfers, then source 1 gets 4, then source 0 again.
- Owner 3 with `out_ready` = 0 for 5 cycles → `selector` = 3 and `out_valid` = 1 are stable and no `ack` issues; `out_ready` = 1 → exactly one `ack[3]`.
- Owner 4 drops `req` with no handshake → next cycle IDLE (or the next requester is granted), no `ack[4]`; `reset_n` = 0 mid-GRANT → all outputs 0 immediately.
- `MUX6_ARB_PRIORITY_EN` defined, source 2 in a locked burst, `req[0]` rises → after the current handshake `selector` = 0; source 2 resumes afterwards.
